// File: rtl/regbus_ctrl.sv
// Operand-read / writeback controller for a register array on shared read buses.
// Define REGBUS_BYPASS_EN to forward an in-flight store into operands captured during DRIVE.
module regbus_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [31:0]     enable_a,
    output logic [31:0]     enable_b,
    input  logic [XLEN-1:0] a_bus,
    input  logic [XLEN-1:0] b_bus,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [31:0]     store,
    output logic [XLEN-1:0] data
);

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    state_t    state;
    logic [4:0] rs1_q;
    logic [4:0] rs2_q;

    // Register x0 is hardwired to zero, so it is never enabled or written.
    function automatic logic [31:0] onehot(input logic [4:0] idx);
        onehot = '0;
        if (idx != '0) onehot[idx] = 1'b1;
    endfunction

    // Ready flags decode from reset_n so they rise in the very first cycle out of reset.
    assign req_ready = reset_n && (state == IDLE);
    assign wb_ready  = reset_n;

    logic [XLEN-1:0] cap_a;
    logic [XLEN-1:0] cap_b;

`ifdef REGBUS_BYPASS_EN
    always_comb begin
        cap_a = (store[rs1_q]) ? data : a_bus;
        cap_b = (store[rs2_q]) ? data : b_bus;
    end
`else
    always_comb begin
        cap_a = a_bus;
        cap_b = b_bus;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            enable_a <= '0;
            enable_b <= '0;
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            store    <= '0;
            data     <= '0;
        end else begin
            store <= '0;
            if (wb_valid && wb_rd != '0) begin
                store <= onehot(wb_rd);
                data  <= wb_data;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rs1_q    <= rs1;
                        rs2_q    <= rs2;
                        enable_a <= onehot(rs1);
                        enable_b <= onehot(rs2);
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    enable_a <= '0;
                    enable_b <= '0;
                    op_a     <= (rs1_q == '0) ? '0 : cap_a;
                    op_b     <= (rs2_q == '0) ? '0 : cap_b;
                    op_valid <= 1'b1;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    enable_a <= '0;
                    enable_b <= '0;
                    op_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbus_ctrl.sv
// Scoreboard bench for regbus_ctrl: a behavioural register array sits on the read buses.
module tb_regbus_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            req_valid;
    logic            req_ready;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     enable_a;
    logic [31:0]     enable_b;
    logic [XLEN-1:0] a_bus;
    logic [XLEN-1:0] b_bus;
    logic            op_valid;
    logic            op_ready;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [31:0]     store;
    logic [XLEN-1:0] data;

    regbus_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .rs1(rs1), .rs2(rs2),
        .enable_a(enable_a), .enable_b(enable_b), .a_bus(a_bus), .b_bus(b_bus),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .store(store), .data(data)
    );

    always #5 clk = ~clk;

    // Register array: written by store strobes, read onto the buses by enables.
    logic [XLEN-1:0] regs [32];
    always @(posedge clk) begin
        for (int i = 0; i < 32; i++)
            if (store[i]) regs[i] <= data;
    end
    // An undriven bus reads as 0 in two-state simulation.
    always_comb begin
        a_bus = '0;
        b_bus = '0;
        for (int i = 0; i < 32; i++) begin
            if (enable_a[i]) a_bus = regs[i];
            if (enable_b[i]) b_bus = regs[i];
        end
    end

    typedef struct packed { logic [XLEN-1:0] a; logic [XLEN-1:0] b; } op_t;
    typedef struct packed { logic [31:0] st; logic [XLEN-1:0] d; } st_t;
    op_t op_q[$];
    st_t st_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Operand and store monitors pop expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        op_t e;
        st_t s;
        if (reset_n) begin
            if (op_valid && op_ready) begin
                if (op_q.size() == 0) check("op_unexpected", 64'd1, 64'd0);
                else begin
                    e = op_q.pop_front();
                    check("op_a", 64'(op_a), 64'(e.a));
                    check("op_b", 64'(op_b), 64'(e.b));
                end
            end
            if (store != '0) begin
                if (st_q.size() == 0) check("store_unexpected", 64'(store), 64'd0);
                else begin
                    s = st_q.pop_front();
                    check("store", 64'(store), 64'(s.st));
                    check("store_data", 64'(data), 64'(s.d));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [XLEN-1:0] v, input logic [31:0] exp_st);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = v;
        if (exp_st != '0) st_q.push_back('{st: exp_st, d: v});
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic rd_req(input logic [4:0] a, input logic [4:0] b,
                          input logic [31:0] en_a, input logic [31:0] en_b,
                          input logic [XLEN-1:0] ea, input logic [XLEN-1:0] eb,
                          input bit push);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 64'd0, 64'd1);
            return;
        end
        req_valid = 1'b1;
        rs1 = a;
        rs2 = b;
        if (push) op_q.push_back('{a: ea, b: eb});
        tick();
        req_valid = 1'b0;
        check("drive_enable_a", 64'(enable_a), 64'(en_a));
        check("drive_enable_b", 64'(enable_b), 64'(en_b));
        check("drive_req_ready", 64'(req_ready), 64'd0);
        check("drive_op_valid", 64'(op_valid), 64'd0);
        tick();
        check("latency_op_valid", 64'(op_valid), 64'd1);
        check("hold_enable_a", 64'(enable_a), 64'd0);
        check("hold_req_ready", 64'(req_ready), 64'd0);
        if (op_ready) begin
            tick();
            check("done_op_valid", 64'(op_valid), 64'd0);
            check("done_req_ready", 64'(req_ready), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XLEN-1:0] haz_exp;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        rs1       = '0;
        rs2       = '0;
        op_ready  = 1'b1;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        repeat (3) tick();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_wb_ready", 64'(wb_ready), 64'd0);
        check("rst_op_valid", 64'(op_valid), 64'd0);
        check("rst_store", 64'(store), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        check("rst_enables", {enable_a, enable_b}, 64'd0);
        reset_n = 1'b1;
        #1;
        check("post_rst_req_ready", 64'(req_ready), 64'd1);
        check("post_rst_wb_ready", 64'(wb_ready), 64'd1);

        // Back-to-back writebacks, then x0 writeback that must not strobe.
        wb(5'd5, 32'h11, 32'h20);
        wb(5'd9, 32'h22, 32'h200);
        wb(5'd7, 32'hDEADBEEF, 32'h80);
        wb(5'd0, 32'h5555, 32'h0);
        check("x0_wb_no_store", 64'(store), 64'd0);
        check("x0_wb_data_held", 64'(data), 64'hDEADBEEF);
        check("wb_ready_steady", 64'(wb_ready), 64'd1);
        tick();

        rd_req(5'd5, 5'd9, 32'h20, 32'h200, 32'h11, 32'h22, 1'b1);
        rd_req(5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

        // Store to reg3 active during the DRIVE cycle of a read of reg3.
        wb(5'd3, 32'h1, 32'h8);
        tick();
`ifdef REGBUS_BYPASS_EN
        haz_exp = 32'h2;
`else
        haz_exp = 32'h1;
`endif
        req_valid = 1'b1;
        rs1 = 5'd3;
        rs2 = 5'd5;
        wb_valid = 1'b1;
        wb_rd = 5'd3;
        wb_data = 32'h2;
        st_q.push_back('{st: 32'h8, d: 32'h2});
        op_q.push_back('{a: haz_exp, b: 32'h11});
        tick();
        req_valid = 1'b0;
        wb_valid = 1'b0;
        check("haz_enable_a", 64'(enable_a), 64'h8);
        check("haz_store", 64'(store), 64'h8);
        tick();
        check("haz_op_valid", 64'(op_valid), 64'd1);
        tick();
        check("haz_done_req_ready", 64'(req_ready), 64'd1);

        // Backpressure: operands must stay put while op_ready is low.
        op_ready = 1'b0;
        rd_req(5'd9, 5'd7, 32'h200, 32'h80, 32'h22, 32'hDEADBEEF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_op_valid", 64'(op_valid), 64'd1);
            check("bp_op_a", 64'(op_a), 64'h22);
            check("bp_op_b", 64'(op_b), 64'hDEADBEEF);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            req_valid = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        op_ready = 1'b1;
        tick();
        check("bp_release_op_valid", 64'(op_valid), 64'd0);
        check("bp_release_req_ready", 64'(req_ready), 64'd1);

        // Reset while in HOLD with a writeback sampled at the reset edge.
        op_ready = 1'b0;
        rd_req(5'd5, 5'd9, 32'h20, 32'h200, 32'h11, 32'h22, 1'b0);
        reset_n  = 1'b0;
        wb_valid = 1'b1;
        wb_rd    = 5'd4;
        wb_data  = 32'h99;
        tick();
        wb_valid = 1'b0;
        check("midrst_op_valid", 64'(op_valid), 64'd0);
        check("midrst_op_a", 64'(op_a), 64'd0);
        check("midrst_op_b", 64'(op_b), 64'd0);
        check("midrst_store", 64'(store), 64'd0);
        check("midrst_data", 64'(data), 64'd0);
        check("midrst_enables", {enable_a, enable_b}, 64'd0);
        check("midrst_readies", {62'd0, req_ready, wb_ready}, 64'd0);
        reset_n  = 1'b1;
        op_ready = 1'b1;
        #1;
        check("midrst_post_req_ready", 64'(req_ready), 64'd1);
        tick();
        check("midrst_no_late_store", 64'(store), 64'd0);
        rd_req(5'd5, 5'd9, 32'h20, 32'h200, 32'h11, 32'h22, 1'b1);

        repeat (3) tick();
        check("op_queue_drained", 64'(op_q.size()), 64'd0);
        check("store_queue_drained", 64'(st_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
